apb4_master: RTL
================

# apb4_master

APB4 requester that bridges a simple valid/ready command/response port onto an APB4 bus. It lets an on-chip controller (debug bridge, DMA, boot sequencer) drive APB4 peripherals such as the GPIO and timer blocks. The sequencing is SETUP → ACCESS with wait-state handling, slave-error capture and a programmable access timeout. One transfer is outstanding at a time.

## Interface
- ADDR_WIDTH, 32, paddr / req_addr width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT, 256, max ACCESS cycles before abort; 0 disables the timeout
- hclk  in  1  clock
- hrst  in  1  reset: synchronous, active-high
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high with req_valid
- req_addr  in  ADDR_WIDTH  target byte address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  DATA_WIDTH/8  write byte strobes
- req_prot  in  3  pprot value
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err  out  1  pslerr seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- paddr  out  ADDR_WIDTH  APB address
- pprot  out  3  APB protection
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  DATA_WIDTH/8  APB strobes; forced to 0 on reads
- pready  in  1  slave ready
- prdata  in  DATA_WIDTH  slave read data
- pslerr  in  1  slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/write/wdata/strb/prot into bus registers and go to SETUP.
- SETUP:
  - psel=1, penable=0.
  - Always advances to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1.
  - Bus outputs are held stable throughout.
  - On pready=1: capture prdata (reads only, else 0) and pslerr into the response registers; go to RESP.
  - On pready=0: increment the wait counter.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT-1 without pready: go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- RESP:
  - psel=penable=0; rsp_valid=1.
  - Response fields are held until rsp_ready; on the handshake, go to IDLE.
- req_ready is 0 in every state except IDLE.
- pready, prdata and pslerr are ignored outside ACCESS.
- Reset values:
  - State is IDLE.
  - req_ready=0 during reset, 1 in the first cycle after reset.
  - All other outputs (rsp_*, psel, penable, pwrite, paddr, pwdata, pstrb, pprot) are 0.
- Reset mid-transfer: the bus is dropped (psel=0) at the next edge and the pending response is discarded; no response is ever issued for it.
- The wait counter is clog2(TIMEOUT)+1 bits wide, clears on entry to SETUP and saturates (never wraps).

## Timing
- Request handshake at edge N → SETUP visible cycle N+1 → ACCESS cycle N+2.
- With pready=1 in the first ACCESS cycle, rsp_valid rises in cycle N+3.
- With W wait states, rsp_valid rises in cycle N+3+W.
- Timeout case:
  - W reaches TIMEOUT-1 in the last ACCESS cycle.
  - rsp_valid rises in cycle N+2+TIMEOUT.
  - Exactly TIMEOUT ACCESS cycles are driven.
- Minimum request-to-request spacing is 4 cycles (IDLE, SETUP, ACCESS, RESP with rsp_ready=1).
- If pready=1 arrives in the same cycle the timeout would fire, pready wins: normal completion, rsp_timeout=0.
- All outputs are registered; there is no combinational path from pready or rsp_ready to any output.

## Structure
- Package apb4_master_pkg:
  - state enum (IDLE, SETUP, ACCESS, RESP);
  - localparam PROT_DEFAULT=3'b000;
  - function computing strobe width.
- Sub-module apb4_wait_cnt:
  - saturating counter with clear, enable and limit compare;
  - outputs expired;
  - parameter LIMIT.
  - It is also reusable by other bus requesters.

## Test plan
- Read, zero wait:
  - Stimulus: req addr=0x04, write=0; slave pready=1 with prdata=0xA5A5_0001.
  - Required: rsp_valid at N+3, rsp_rdata=0xA5A5_0001, rsp_err=0; psel high for 2 cycles, penable for 1.
- Write with 3 wait states:
  - Stimulus: addr=0x08, wdata=0xDEAD_BEEF, strb=4'hF.
  - Required: paddr, pwdata and pstrb stable for 4 ACCESS cycles; rsp_valid at N+6; rsp_rdata=0.
- Slave error:
  - Stimulus: read with pslerr=1 and pready=1.
  - Required: rsp_err=1, rsp_timeout=0.
- Timeout:
  - Stimulus: TIMEOUT=8, pready held at 0.
  - Required: exactly 8 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; psel=0 afterwards.
  - Variant: pready=1 in the 8th ACCESS cycle gives a normal completion.
- Backpressure and back-to-back:
  - Stimulus: hold rsp_ready=0 for 5 cycles, with req_valid asserted continuously.
  - Required: response fields stable and req_ready=0 throughout; the second request is accepted the cycle after the rsp handshake.
- Reset mid-ACCESS:
  - Stimulus: assert hrst during wait states.
  - Required: next edge gives psel=penable=rsp_valid=0 and state IDLE; the following request completes normally.

Source files
------------

// File: rtl/apb4_master_pkg.sv
// Shared types and helpers for the APB4 requester: FSM state encoding,
// default protection value and strobe-width helper.
package apb4_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 32'd8;
    endfunction

endpackage

// File: rtl/apb4_wait_cnt.sv
// Saturating wait-state counter with clear/enable and a limit compare.
// A LIMIT of 0 disables expiry; usable by any bus requester needing an access timeout.
module apb4_wait_cnt #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CW     = $clog2(LIMIT) + 1;
    localparam logic        TO_EN  = (LIMIT != 32'd0);
    localparam logic [CW-1:0] LAST = TO_EN ? CW'(LIMIT - 32'd1) : {CW{1'b0}};
    localparam logic [CW-1:0] MAX  = {CW{1'b1}};

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear has priority, increment stops at all-ones so it never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + CW'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = TO_EN && (cnt_q >= LAST);

endmodule

// File: rtl/apb4_master.sv
// APB4 requester: bridges a valid/ready command/response port onto an APB4 bus,
// one transfer outstanding, with wait states, slave-error capture and access timeout.
module apb4_master
    import apb4_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                              hclk,
    input  logic                              hrst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic                              req_write,
    input  logic [DATA_WIDTH-1:0]             req_wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0] req_strb,
    input  logic [2:0]                        req_prot,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              rsp_err,
    output logic                              rsp_timeout,
    output logic [ADDR_WIDTH-1:0]             paddr,
    output logic [2:0]                        pprot,
    output logic                              psel,
    output logic                              penable,
    output logic                              pwrite,
    output logic [DATA_WIDTH-1:0]             pwdata,
    output logic [strb_width(DATA_WIDTH)-1:0] pstrb,
    input  logic                              pready,
    input  logic [DATA_WIDTH-1:0]             prdata,
    input  logic                              pslerr
);
    localparam int unsigned SW = strb_width(DATA_WIDTH);

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0]         pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic accept_s;
    logic wait_en_s;
    logic wait_expired_s;

    // req_ready_q also gates acceptance so nothing is taken in the cycle right after reset
    assign accept_s  = (state_q == ST_IDLE) && req_ready_q && req_valid;
    assign wait_en_s = (state_q == ST_ACCESS) && !pready;

    apb4_wait_cnt #(
        .LIMIT (TIMEOUT)
    ) u_wait_cnt (
        .clk_i     (hclk),
        .rst_i     (hrst),
        .clr_i     (accept_s),
        .en_i      (wait_en_s),
        .expired_o (wait_expired_s)
    );

    // Next-state and next-output logic; outputs are derived from the next state so they stay registered
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d  = ST_SETUP;
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    pstrb_d  = req_write ? req_strb : {SW{1'b0}};
                    pprot_d  = req_prot;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready takes priority over a timeout expiring in the same cycle
                if (pready) begin
                    state_d       = ST_RESP;
                    rsp_rdata_d   = pwrite_q ? {DATA_WIDTH{1'b0}} : prdata;
                    rsp_err_d     = pslerr;
                    rsp_timeout_d = 1'b0;
                end else if (wait_expired_s) begin
                    state_d       = ST_RESP;
                    rsp_rdata_d   = {DATA_WIDTH{1'b0}};
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // FSM state register
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered bus and response outputs
    always_ff @(posedge hclk) begin
        if (hrst) begin
            req_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= {ADDR_WIDTH{1'b0}};
            pwdata_q      <= {DATA_WIDTH{1'b0}};
            pstrb_q       <= {SW{1'b0}};
            pprot_q       <= PROT_DEFAULT;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= {DATA_WIDTH{1'b0}};
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            req_ready_q   <= req_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign pprot       = pprot_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
